pipe_stage_reg: RTL and testbench

- Parametrised successor to the fixed MEM/WB pipeline register of the 5-stage MIPS core.
- Provides a chain of DEPTH identical register stages with stall (hold) and flush (bubble insert).
- Carries the T_new countdown and a valid bit, and flags when the last stage is a ready forwarding source.
- Used for M/W, and for extra retiming stages behind multi-cycle units.

---
 rtl/pipe_stage_reg_if.sv | 46 ++++
 rtl/pipe_stage_reg.sv | 137 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
// Bus bundle for pipe_stage_reg: upstream stage fields in, last-stage fields and perf counters out.
interface pipe_stage_reg_if #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned TNEW_W     = 2
);
   logic                  valid_i;
   logic [DATA_W-1:0]     pc_i;
   logic [DATA_W-1:0]     instr_i;
   logic                  reg_write_i;
   logic                  mem_to_reg_i;
   logic                  link_i;
   logic [DATA_W-1:0]     alu_out_i;
   logic [DATA_W-1:0]     read_data_i;
   logic [REG_ADDR_W-1:0] write_reg_i;
   logic [TNEW_W-1:0]     t_new_i;

   logic                  valid_o;
   logic [DATA_W-1:0]     pc_o;
   logic [DATA_W-1:0]     instr_o;
   logic                  reg_write_o;
   logic                  mem_to_reg_o;
   logic                  link_o;
   logic [DATA_W-1:0]     alu_out_o;
   logic [DATA_W-1:0]     read_data_o;
   logic [REG_ADDR_W-1:0] write_reg_o;
   logic [TNEW_W-1:0]     t_new_o;
   logic [DATA_W-1:0]     wb_data_o;
   logic                  fwd_ready_o;
   logic [31:0]           bubble_cnt_o;
   logic [31:0]           stall_cnt_o;

   modport master (
      output valid_i, pc_i, instr_i, reg_write_i, mem_to_reg_i, link_i, alu_out_i, read_data_i,
             write_reg_i, t_new_i,
      input  valid_o, pc_o, instr_o, reg_write_o, mem_to_reg_o, link_o, alu_out_o, read_data_o,
             write_reg_o, t_new_o, wb_data_o, fwd_ready_o, bubble_cnt_o, stall_cnt_o
   );

   modport slave (
      input  valid_i, pc_i, instr_i, reg_write_i, mem_to_reg_i, link_i, alu_out_i, read_data_i,
             write_reg_i, t_new_i,
      output valid_o, pc_o, instr_o, reg_write_o, mem_to_reg_o, link_o, alu_out_o, read_data_o,
             write_reg_o, t_new_o, wb_data_o, fwd_ready_o, bubble_cnt_o, stall_cnt_o
   );
endinterface

// File: rtl/pipe_stage_reg.sv
// DEPTH-deep pipeline register chain (M/W and retiming) with stall, flush and T_new countdown.
// Optional perf counters enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned TNEW_W     = 2,
   parameter int unsigned TNEW_RST   = 3,
   parameter int unsigned DEPTH      = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall_i,
   input  logic             flush_i,
   pipe_stage_reg_if.slave  bus
);

   typedef struct packed {
      logic                  valid;
      logic [DATA_W-1:0]     pc;
      logic [DATA_W-1:0]     instr;
      logic                  reg_write;
      logic                  mem_to_reg;
      logic                  link;
      logic [DATA_W-1:0]     alu_out;
      logic [DATA_W-1:0]     read_data;
      logic [REG_ADDR_W-1:0] write_reg;
      logic [TNEW_W-1:0]     t_new;
   } stage_t;

   function automatic logic [TNEW_W-1:0] dec_sat(input logic [TNEW_W-1:0] t);
      return (t != '0) ? t - TNEW_W'(1) : '0;
   endfunction

   stage_t in_s;
   stage_t rst_s;
   stage_t last_s;
   stage_t up_s    [DEPTH];
   stage_t stage_d [DEPTH];
   stage_t stage_q [DEPTH];

   always_comb begin
      in_s            = '0;
      in_s.valid      = bus.valid_i;
      in_s.pc         = bus.pc_i;
      in_s.instr      = bus.instr_i;
      in_s.reg_write  = bus.reg_write_i;
      in_s.mem_to_reg = bus.mem_to_reg_i;
      in_s.link       = bus.link_i;
      in_s.alu_out    = bus.alu_out_i;
      in_s.read_data  = bus.read_data_i;
      in_s.write_reg  = bus.write_reg_i;
      in_s.t_new      = bus.t_new_i;
   end

   always_comb begin
      rst_s       = '0;
      rst_s.t_new = TNEW_W'(TNEW_RST);
   end

   assign up_s[0] = in_s;
   for (genvar k = 1; k < DEPTH; k++) begin : g_chain
      assign up_s[k] = stage_q[k-1];
   end

   // Flush keeps pc flowing so the EPC trail survives the bubble.
   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         stage_d[k]       = up_s[k];
         stage_d[k].t_new = dec_sat(up_s[k].t_new);
         if (flush_i) begin
            stage_d[k]         = up_s[k];
            stage_d[k].valid      = 1'b0;
            stage_d[k].reg_write  = 1'b0;
            stage_d[k].mem_to_reg = 1'b0;
            stage_d[k].link       = 1'b0;
            stage_d[k].write_reg  = '0;
            stage_d[k].instr      = '0;
            stage_d[k].t_new      = '0;
         end else if (stall_i) begin
            stage_d[k]       = stage_q[k];
            stage_d[k].t_new = dec_sat(stage_q[k].t_new);
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < DEPTH; k++) begin
         if (reset) stage_q[k] <= rst_s;
         else       stage_q[k] <= stage_d[k];
      end
   end

   assign last_s = stage_q[DEPTH-1];

   assign bus.valid_o      = last_s.valid;
   assign bus.pc_o         = last_s.pc;
   assign bus.instr_o      = last_s.instr;
   assign bus.reg_write_o  = last_s.reg_write;
   assign bus.mem_to_reg_o = last_s.mem_to_reg;
   assign bus.link_o       = last_s.link;
   assign bus.alu_out_o    = last_s.alu_out;
   assign bus.read_data_o  = last_s.read_data;
   assign bus.write_reg_o  = last_s.write_reg;
   assign bus.t_new_o      = last_s.t_new;

   assign bus.wb_data_o   = last_s.link       ? last_s.pc + DATA_W'(8) :
                            last_s.mem_to_reg ? last_s.read_data : last_s.alu_out;
   assign bus.fwd_ready_o = last_s.valid & last_s.reg_write & (last_s.write_reg != '0) &
                            (last_s.t_new == '0);

`ifdef PIPE_STAGE_PERF_EN
   logic [31:0] bubble_cnt_q, bubble_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      bubble_cnt_d = flush_i ? bubble_cnt_q + 32'd1 : bubble_cnt_q;
      stall_cnt_d  = (stall_i && !flush_i) ? stall_cnt_q + 32'd1 : stall_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bubble_cnt_q <= '0;
         stall_cnt_q  <= '0;
      end else begin
         bubble_cnt_q <= bubble_cnt_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign bus.bubble_cnt_o = bubble_cnt_q;
   assign bus.stall_cnt_o  = stall_cnt_q;
`else
   assign bus.bubble_cnt_o = '0;
   assign bus.stall_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a DEPTH=1 instance and a DEPTH=3 instance.
module tb_pipe_stage_reg;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        rw;
      logic        m2r;
      logic        link;
      logic [31:0] alu;
      logic [31:0] rd;
      logic [4:0]  wr;
      logic [1:0]  tn;
   } rec_t;

   typedef struct {
      int   due;
      rec_t r;
   } sb_t;

   logic clk = 1'b0;
   logic reset;
   logic stall1, flush1, stall3, flush3;
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;

   rec_t q1[$];
   sb_t  q3[$];

   pipe_stage_reg_if #(.DATA_W(32), .REG_ADDR_W(5), .TNEW_W(2)) bus1 ();
   pipe_stage_reg_if #(.DATA_W(32), .REG_ADDR_W(5), .TNEW_W(2)) bus3 ();

   pipe_stage_reg #(.DATA_W(32), .REG_ADDR_W(5), .TNEW_W(2), .TNEW_RST(3), .DEPTH(1)) u_dut1 (
      .clk     (clk),
      .reset   (reset),
      .stall_i (stall1),
      .flush_i (flush1),
      .bus     (bus1)
   );

   pipe_stage_reg #(.DATA_W(32), .REG_ADDR_W(5), .TNEW_W(2), .TNEW_RST(3), .DEPTH(3)) u_dut3 (
      .clk     (clk),
      .reset   (reset),
      .stall_i (stall3),
      .flush_i (flush3),
      .bus     (bus3)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [1:0] dec(input logic [1:0] t);
      return (t != 2'd0) ? t - 2'd1 : 2'd0;
   endfunction

   function automatic rec_t load_model(input rec_t r);
      rec_t o;
      o    = r;
      o.tn = dec(r.tn);
      return o;
   endfunction

   function automatic logic [31:0] wb_of(input rec_t r);
      return r.link ? r.pc + 32'd8 : (r.m2r ? r.rd : r.alu);
   endfunction

   function automatic logic fwd_of(input rec_t r);
      return r.valid & r.rw & (r.wr != 5'd0) & (r.tn == 2'd0);
   endfunction

   function automatic rec_t rand_rec();
      rec_t r;
      r.valid = 1'($urandom_range(0, 1));
      r.pc    = $urandom;
      r.instr = $urandom;
      r.rw    = 1'($urandom_range(0, 1));
      r.m2r   = 1'($urandom_range(0, 1));
      r.link  = 1'($urandom_range(0, 1));
      r.alu   = $urandom;
      r.rd    = $urandom;
      r.wr    = 5'($urandom_range(0, 31));
      r.tn    = 2'($urandom_range(0, 3));
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive1(input rec_t r);
      bus1.valid_i = r.valid;  bus1.pc_i = r.pc;  bus1.instr_i = r.instr;
      bus1.reg_write_i = r.rw;  bus1.mem_to_reg_i = r.m2r;  bus1.link_i = r.link;
      bus1.alu_out_i = r.alu;  bus1.read_data_i = r.rd;  bus1.write_reg_i = r.wr;
      bus1.t_new_i = r.tn;
   endtask

   task automatic drive3(input rec_t r);
      bus3.valid_i = r.valid;  bus3.pc_i = r.pc;  bus3.instr_i = r.instr;
      bus3.reg_write_i = r.rw;  bus3.mem_to_reg_i = r.m2r;  bus3.link_i = r.link;
      bus3.alu_out_i = r.alu;  bus3.read_data_i = r.rd;  bus3.write_reg_i = r.wr;
      bus3.t_new_i = r.tn;
   endtask

   task automatic cmp1(input string tag, input rec_t e);
      check_eq({tag, ".valid"}, 64'(bus1.valid_o), 64'(e.valid));
      check_eq({tag, ".pc"}, 64'(bus1.pc_o), 64'(e.pc));
      check_eq({tag, ".instr"}, 64'(bus1.instr_o), 64'(e.instr));
      check_eq({tag, ".rw"}, 64'(bus1.reg_write_o), 64'(e.rw));
      check_eq({tag, ".m2r"}, 64'(bus1.mem_to_reg_o), 64'(e.m2r));
      check_eq({tag, ".link"}, 64'(bus1.link_o), 64'(e.link));
      check_eq({tag, ".alu"}, 64'(bus1.alu_out_o), 64'(e.alu));
      check_eq({tag, ".rd"}, 64'(bus1.read_data_o), 64'(e.rd));
      check_eq({tag, ".wr"}, 64'(bus1.write_reg_o), 64'(e.wr));
      check_eq({tag, ".tnew"}, 64'(bus1.t_new_o), 64'(e.tn));
      check_eq({tag, ".wb"}, 64'(bus1.wb_data_o), 64'(wb_of(e)));
      check_eq({tag, ".fwd"}, 64'(bus1.fwd_ready_o), 64'(fwd_of(e)));
   endtask

   task automatic cmp3(input string tag, input rec_t e);
      check_eq({tag, ".valid"}, 64'(bus3.valid_o), 64'(e.valid));
      check_eq({tag, ".pc"}, 64'(bus3.pc_o), 64'(e.pc));
      check_eq({tag, ".instr"}, 64'(bus3.instr_o), 64'(e.instr));
      check_eq({tag, ".wr"}, 64'(bus3.write_reg_o), 64'(e.wr));
      check_eq({tag, ".tnew"}, 64'(bus3.t_new_o), 64'(e.tn));
      check_eq({tag, ".wb"}, 64'(bus3.wb_data_o), 64'(wb_of(e)));
      check_eq({tag, ".fwd"}, 64'(bus3.fwd_ready_o), 64'(fwd_of(e)));
   endtask

   initial begin
      rec_t v, e, held, rst_rec;
      sb_t  s;
      int   nvalid;
      logic [31:0] exp_stall, exp_bubble;
      logic [1:0] sf [8];

      rst_rec    = '0;
      rst_rec.tn = 2'd3;
      stall1 = 1'b0; flush1 = 1'b0; stall3 = 1'b0; flush3 = 1'b0;

      // Reset with random inputs
      reset = 1'b1;
      drive1(rand_rec());
      drive3(rand_rec());
      step();
      drive1(rand_rec());
      step();
      cmp1("reset", rst_rec);
      check_eq("reset3.valid", 64'(bus3.valid_o), 64'd0);
      check_eq("reset3.tnew", 64'(bus3.t_new_o), 64'd3);
      check_eq("reset.bubble", 64'(bus1.bubble_cnt_o), 64'd0);
      check_eq("reset.stall", 64'(bus1.stall_cnt_o), 64'd0);
      reset = 1'b0;
      drive3('0);

      // Load vectors through DEPTH=1
      v = '0; v.valid = 1'b1; v.rw = 1'b1; v.wr = 5'd8; v.alu = 32'h1234; v.tn = 2'd1;
      v.pc = 32'h3000; v.instr = 32'h0123_4567;
      drive1(v); q1.push_back(load_model(v)); step(); e = q1.pop_front(); cmp1("load", e);
      v.tn = 2'd0; v.alu = 32'h5678;
      drive1(v); q1.push_back(load_model(v)); step(); e = q1.pop_front(); cmp1("sat0", e);
      v.link = 1'b1; v.pc = 32'h0000_3004;
      drive1(v); q1.push_back(load_model(v)); step(); e = q1.pop_front(); cmp1("link", e);
      v.pc = 32'hFFFF_FFFC;
      drive1(v); q1.push_back(load_model(v)); step(); e = q1.pop_front(); cmp1("linkwrap", e);
      v.link = 1'b0; v.m2r = 1'b1; v.rd = 32'hDEAD_BEEF; v.wr = 5'd0;
      drive1(v); q1.push_back(load_model(v)); step(); e = q1.pop_front(); cmp1("m2r", e);
      for (int i = 0; i < 4; i++) begin
         v = rand_rec();
         drive1(v); q1.push_back(load_model(v)); step(); e = q1.pop_front(); cmp1("rand", e);
      end

      // Stall: t_new keeps counting down while everything else holds
      v = rand_rec(); v.valid = 1'b1; v.rw = 1'b1; v.wr = 5'd3; v.tn = 2'd3;
      drive1(v); held = load_model(v); q1.push_back(held); step();
      e = q1.pop_front(); cmp1("preStall", e);
      stall1 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive1(rand_rec());
         held.tn = dec(held.tn);
         q1.push_back(held);
         step();
         e = q1.pop_front();
         cmp1("stall", e);
      end

      // Flush wins over stall
      flush1 = 1'b1;
      v = rand_rec(); v.valid = 1'b1; v.rw = 1'b1; v.wr = 5'd9; v.pc = 32'h3010;
      drive1(v); step();
      check_eq("flush.valid", 64'(bus1.valid_o), 64'd0);
      check_eq("flush.rw", 64'(bus1.reg_write_o), 64'd0);
      check_eq("flush.wr", 64'(bus1.write_reg_o), 64'd0);
      check_eq("flush.pc", 64'(bus1.pc_o), 64'h3010);
      check_eq("flush.instr", 64'(bus1.instr_o), 64'd0);
      check_eq("flush.tnew", 64'(bus1.t_new_o), 64'd0);
      check_eq("flush.link", 64'(bus1.link_o), 64'd0);
      check_eq("flush.fwd", 64'(bus1.fwd_ready_o), 64'd0);
      flush1 = 1'b0; stall1 = 1'b0;

      // Reset mid-operation
      v = rand_rec(); v.valid = 1'b1;
      drive1(v); step();
      check_eq("preRst.valid", 64'(bus1.valid_o), 64'd1);
      reset = 1'b1; step(); reset = 1'b0;
      cmp1("midRst", rst_rec);

      // DEPTH=3 stream: 5 instructions then bubbles, each due 3 edges later
      drive1('0);
      reset = 1'b1; step(); reset = 1'b0;
      cyc = 0; nvalid = 0;
      for (int c = 0; c < 11; c++) begin
         if (c < 8) begin
            v = rand_rec();
            v.valid = (c < 5);
            if (c < 5) v.pc = 32'h4000 + 32'(c * 4);
            drive3(v);
            s.due = cyc + 3;
            s.r   = load_model(load_model(load_model(v)));
            q3.push_back(s);
         end else begin
            drive3('0);
         end
         step();
         cyc++;
         while (q3.size() > 0 && q3[0].due == cyc) begin
            s = q3.pop_front();
            if (bus3.valid_o) nvalid++;
            cmp3("d3", s.r);
         end
      end
      check_eq("d3.drained", 64'(q3.size()), 64'd0);
      check_eq("d3.nvalid", 64'(nvalid), 64'd5);

      // Perf counters: stall, flush, flush+stall, idle
      reset = 1'b1; step(); reset = 1'b0;
      exp_stall = '0; exp_bubble = '0;
      sf = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b11, 2'b00};
      for (int i = 0; i < 8; i++) begin
         stall3 = sf[i][1];
         flush3 = sf[i][0];
         step();
`ifdef PIPE_STAGE_PERF_EN
         if (sf[i][0]) exp_bubble++;
         else if (sf[i][1]) exp_stall++;
`endif
      end
      stall3 = 1'b0; flush3 = 1'b0;
      check_eq("perf.stall", 64'(bus3.stall_cnt_o), 64'(exp_stall));
      check_eq("perf.bubble", 64'(bus3.bubble_cnt_o), 64'(exp_bubble));
      check_eq("perf.idle1", 64'(bus1.stall_cnt_o), 64'd0);
`ifdef PIPE_STAGE_PERF_EN
      force u_dut3.stall_cnt_q = 32'hFFFF_FFFF;
      #1;
      release u_dut3.stall_cnt_q;
      stall3 = 1'b1;
      step();
      stall3 = 1'b0;
      check_eq("perf.wrap", 64'(bus3.stall_cnt_o), 64'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
